// File: rtl/id_ex_alu_ctrl.sv
// ID/EX issue stage: decodes an RV32I instruction into a 3-bit ALU control code and
// both operands, registers them for the EX-stage ALU, and counts unsupported instructions.
module id_ex_alu_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [31:0]      instr_i,
    input  logic [31:0]      rs1_data_i,
    input  logic [31:0]      rs2_data_i,
    input  logic             stall_i,
    input  logic             flush_i,
    output logic             valid_o,
    output logic [2:0]       ALUCtrl_o,
    output logic [31:0]      data1_o,
    output logic [31:0]      data2_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] illegal_cnt_o
);

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SRA = 3'b110,
        ALU_SRL = 3'b111
    } alu_op_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] shamt;
    logic        unused_rs1_idx;

    assign op    = instr_i[6:0];
    assign f3    = instr_i[14:12];
    assign f7    = instr_i[31:25];
    assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign shamt = {27'd0, instr_i[24:20]};
    // Register indices are resolved upstream; only the read data arrives here.
    assign unused_rs1_idx = ^instr_i[19:15];

    logic        dec_legal;
    alu_op_e     dec_op;
    logic [31:0] dec_b;

    always_comb begin
        // NOTE: every decode output gets a default first, so no path can leave one unassigned and infer a latch.
        dec_legal = 1'b0;
        dec_op    = ALU_ADD;
        dec_b     = rs2_data_i;
        case (op)
            OP_R: begin
                if (f7 == F7_BASE) begin
                    dec_legal = 1'b1;
                    case (f3)
                        3'b000:  dec_op = ALU_ADD;
                        3'b111:  dec_op = ALU_AND;
                        3'b110:  dec_op = ALU_OR;
                        3'b100:  dec_op = ALU_XOR;
                        3'b001:  dec_op = ALU_SLL;
                        3'b101:  dec_op = ALU_SRL;
                        default: dec_legal = 1'b0;
                    endcase
                end else if (f7 == F7_ALT) begin
                    dec_legal = 1'b1;
                    case (f3)
                        3'b000:  dec_op = ALU_SUB;
                        3'b101:  dec_op = ALU_SRA;
                        default: dec_legal = 1'b0;
                    endcase
                end
            end
            OP_I: begin
                dec_b = imm_i;
                case (f3)
                    3'b000: begin dec_legal = 1'b1; dec_op = ALU_ADD; end
                    3'b111: begin dec_legal = 1'b1; dec_op = ALU_AND; end
                    3'b110: begin dec_legal = 1'b1; dec_op = ALU_OR;  end
                    3'b100: begin dec_legal = 1'b1; dec_op = ALU_XOR; end
                    3'b001: begin
                        dec_b     = shamt;
                        dec_legal = (f7 == F7_BASE);
                        dec_op    = ALU_SLL;
                    end
                    3'b101: begin
                        dec_b     = shamt;
                        dec_legal = (f7 == F7_BASE) || (f7 == F7_ALT);
                        dec_op    = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
            OP_LOAD: begin
                dec_legal = 1'b1;
                dec_b     = imm_i;
            end
            OP_STORE: begin
                dec_legal = 1'b1;
                dec_b     = imm_s;
            end
            OP_BRANCH: begin
                dec_legal = 1'b1;
                dec_op    = ALU_SUB;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    logic load_ok;
    logic load_bad;

    assign load_ok  = valid_i && dec_legal;
    assign load_bad = valid_i && !dec_legal;

    // Flush beats stall beats capture; an idle or illegal capture loads a bubble.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values, whatever the statement order.
        if (rst_i) begin
            valid_o       <= 1'b0;
            ALUCtrl_o     <= ALU_ADD;
            data1_o       <= '0;
            data2_o       <= '0;
            illegal_o     <= 1'b0;
            illegal_cnt_o <= '0;
        end else if (flush_i) begin
            valid_o   <= 1'b0;
            ALUCtrl_o <= ALU_ADD;
            data1_o   <= '0;
            data2_o   <= '0;
            illegal_o <= 1'b0;
        end else if (!stall_i) begin
            valid_o   <= load_ok;
            ALUCtrl_o <= load_ok ? dec_op : ALU_ADD;
            data1_o   <= load_ok ? rs1_data_i : '0;
            data2_o   <= load_ok ? dec_b : '0;
            illegal_o <= load_bad;
            if (load_bad && (illegal_cnt_o != '1)) begin
                illegal_cnt_o <= illegal_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_id_ex_alu_ctrl.sv
// Bench for id_ex_alu_ctrl: directed vector table, hand-written stall/flush/reset/illegal
// sequences, then random traffic against an encoding-table reference model.
module tb_id_ex_alu_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic [31:0] instr_i;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic        stall_i;
    logic        flush_i;

    logic        valid_o;
    logic [2:0]  ALUCtrl_o;
    logic [31:0] data1_o;
    logic [31:0] data2_o;
    logic        illegal_o;
    logic [7:0]  illegal_cnt_o;

    logic        s_valid_o;
    logic [2:0]  s_ALUCtrl_o;
    logic [31:0] s_data1_o;
    logic [31:0] s_data2_o;
    logic        s_illegal_o;
    logic [1:0]  s_illegal_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    id_ex_alu_ctrl #(.CNT_W(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .instr_i(instr_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .stall_i(stall_i), .flush_i(flush_i),
        .valid_o(valid_o), .ALUCtrl_o(ALUCtrl_o), .data1_o(data1_o), .data2_o(data2_o),
        .illegal_o(illegal_o), .illegal_cnt_o(illegal_cnt_o)
    );

    id_ex_alu_ctrl #(.CNT_W(2)) dut_small (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .instr_i(instr_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .stall_i(stall_i), .flush_i(flush_i),
        .valid_o(s_valid_o), .ALUCtrl_o(s_ALUCtrl_o), .data1_o(s_data1_o), .data2_o(s_data2_o),
        .illegal_o(s_illegal_o), .illegal_cnt_o(s_illegal_cnt_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: legal encodings as a lookup table keyed by {op, f3, f7}.
    logic [2:0] legal_map [logic [16:0]];

    function automatic logic [16:0] key(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        return {op, f3, f7};
    endfunction

    task automatic build_map();
        legal_map[key(7'h33, 3'd0, 7'h00)] = 3'd0;
        legal_map[key(7'h33, 3'd0, 7'h20)] = 3'd1;
        legal_map[key(7'h33, 3'd7, 7'h00)] = 3'd2;
        legal_map[key(7'h33, 3'd6, 7'h00)] = 3'd3;
        legal_map[key(7'h33, 3'd4, 7'h00)] = 3'd4;
        legal_map[key(7'h33, 3'd1, 7'h00)] = 3'd5;
        legal_map[key(7'h33, 3'd5, 7'h20)] = 3'd6;
        legal_map[key(7'h33, 3'd5, 7'h00)] = 3'd7;
        legal_map[key(7'h13, 3'd0, 7'h00)] = 3'd0;
        legal_map[key(7'h13, 3'd7, 7'h00)] = 3'd2;
        legal_map[key(7'h13, 3'd6, 7'h00)] = 3'd3;
        legal_map[key(7'h13, 3'd4, 7'h00)] = 3'd4;
        legal_map[key(7'h13, 3'd1, 7'h00)] = 3'd5;
        legal_map[key(7'h13, 3'd5, 7'h20)] = 3'd6;
        legal_map[key(7'h13, 3'd5, 7'h00)] = 3'd7;
        legal_map[key(7'h03, 3'd0, 7'h00)] = 3'd0;
        legal_map[key(7'h23, 3'd0, 7'h00)] = 3'd0;
        legal_map[key(7'h63, 3'd0, 7'h00)] = 3'd1;
    endtask

    task automatic ref_decode(input logic [31:0] ins, input logic [31:0] rs1, input logic [31:0] rs2,
                              output logic ok, output logic [2:0] ctrl,
                              output logic [31:0] a, output logic [31:0] b);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       shift_i;
        int         imm;
        op      = ins[6:0];
        f3      = ins[14:12];
        f7      = ins[31:25];
        shift_i = (op == 7'h13) && (f3 == 3'd1 || f3 == 3'd5);
        if (op == 7'h03 || op == 7'h23 || op == 7'h63) f3 = 3'd0;
        if (!(op == 7'h33 || shift_i)) f7 = 7'h00;
        ok   = legal_map.exists(key(op, f3, f7));
        ctrl = ok ? legal_map[key(op, f3, f7)] : 3'd0;
        a    = ok ? rs1 : 32'd0;
        if (op == 7'h23) imm = int'({ins[31:25], ins[11:7]});
        else             imm = int'(ins[31:20]);
        if (imm >= 2048) imm -= 4096;
        if (!ok)                              b = 32'd0;
        else if (shift_i)                     b = 32'(int'(ins[24:20]));
        else if (op == 7'h33 || op == 7'h63)  b = rs2;
        else                                  b = 32'(imm);
    endtask

    logic        m_valid, m_ill;
    logic [2:0]  m_ctrl;
    logic [31:0] m_d1, m_d2;
    int          m_cnt, m_cnt_s;

    task automatic model_reset();
        m_valid = 0; m_ill = 0; m_ctrl = 0; m_d1 = 0; m_d2 = 0; m_cnt = 0; m_cnt_s = 0;
    endtask

    task automatic model_edge();
        logic ok; logic [2:0] c; logic [31:0] a, b;
        if (flush_i || (!stall_i && !valid_i)) begin
            m_valid = 0; m_ill = 0; m_ctrl = 0; m_d1 = 0; m_d2 = 0;
        end else if (!stall_i) begin
            ref_decode(instr_i, rs1_data_i, rs2_data_i, ok, c, a, b);
            m_valid = ok; m_ill = !ok; m_ctrl = c; m_d1 = a; m_d2 = b;
            if (!ok) begin
                if (m_cnt < 255) m_cnt++;
                if (m_cnt_s < 3) m_cnt_s++;
            end
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2,
                         input logic st, input logic fl);
        valid_i = v; instr_i = ins; rs1_data_i = r1; rs2_data_i = r2; stall_i = st; flush_i = fl;
    endtask

    task automatic check_model(input string tag);
        check({tag, " valid"},   32'(valid_o),       32'(m_valid));
        check({tag, " ctrl"},    32'(ALUCtrl_o),     32'(m_ctrl));
        check({tag, " data1"},   data1_o,            m_d1);
        check({tag, " data2"},   data2_o,            m_d2);
        check({tag, " illegal"}, 32'(illegal_o),     32'(m_ill));
        check({tag, " cnt"},     32'(illegal_cnt_o), 32'(m_cnt));
        check({tag, " cnt_s"},   32'(s_illegal_cnt_o), 32'(m_cnt_s));
    endtask

    task automatic check_outs(input string tag, input logic v, input logic [2:0] c, input logic [31:0] d1,
                              input logic [31:0] d2, input logic il);
        check({tag, " valid"},   32'(valid_o),   32'(v));
        check({tag, " ctrl"},    32'(ALUCtrl_o), 32'(c));
        check({tag, " data1"},   data1_o,        d1);
        check({tag, " data2"},   data2_o,        d2);
        check({tag, " illegal"}, 32'(illegal_o), 32'(il));
    endtask

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        valid;
        logic [2:0]  ctrl;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        ill;
    } vec_t;

    vec_t vecs [16];

    initial begin
        vecs[0]  = '{"sub",       32'h40208033, 32'd10,       32'd3,        1, 3'b001, 32'd10,       32'd3,        0};
        vecs[1]  = '{"and",       32'h0020F033, 32'h0000_0F0F, 32'h0000_00FF, 1, 3'b010, 32'h0000_0F0F, 32'h0000_00FF, 0};
        vecs[2]  = '{"or",        32'h0020E033, 32'd1,        32'd2,        1, 3'b011, 32'd1,        32'd2,        0};
        vecs[3]  = '{"xor",       32'h0020C033, 32'd5,        32'd6,        1, 3'b100, 32'd5,        32'd6,        0};
        vecs[4]  = '{"sll",       32'h00209033, 32'd7,        32'd4,        1, 3'b101, 32'd7,        32'd4,        0};
        vecs[5]  = '{"srl",       32'h0020D033, 32'hF000_0000, 32'd4,       1, 3'b111, 32'hF000_0000, 32'd4,       0};
        vecs[6]  = '{"addi",      32'hFFB00093, 32'd100,      32'd9,        1, 3'b000, 32'd100,      32'hFFFF_FFFB, 0};
        vecs[7]  = '{"srai",      32'h4030D093, 32'h8000_0000, 32'd9,       1, 3'b110, 32'h8000_0000, 32'd3,       0};
        vecs[8]  = '{"sw",        32'h0020A423, 32'h1000,     32'h55,       1, 3'b000, 32'h1000,     32'd8,        0};
        vecs[9]  = '{"lw_neg",    32'hFFC12083, 32'h2000,     32'h66,       1, 3'b000, 32'h2000,     32'hFFFF_FFFC, 0};
        vecs[10] = '{"beq",       32'h00208063, 32'd42,       32'd42,       1, 3'b001, 32'd42,       32'd42,       0};
        vecs[11] = '{"xori_neg",  32'h80014093, 32'd3,        32'd0,        1, 3'b100, 32'd3,        32'hFFFF_F800, 0};
        vecs[12] = '{"slt",       32'h0020A033, 32'd1,        32'd2,        0, 3'b000, 32'd0,        32'd0,        1};
        vecs[13] = '{"slli_badf7",32'h40209093, 32'd1,        32'd2,        0, 3'b000, 32'd0,        32'd0,        1};
        vecs[14] = '{"lui",       32'h12345037, 32'd1,        32'd2,        0, 3'b000, 32'd0,        32'd0,        1};
        vecs[15] = '{"srli",      32'h01F0D093, 32'd9,        32'd2,        1, 3'b111, 32'd9,        32'd31,       0};

        build_map();
        model_reset();
        drive(0, 32'h0, 32'h0, 32'h0, 0, 0);
        rst_i = 1'b1;
        #1;
        check_outs("reset", 0, 3'b000, 32'd0, 32'd0, 0);
        check("reset cnt", 32'(illegal_cnt_o), 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("idle valid", 32'(valid_o), 32'd0);
        end

        for (int i = 0; i < 16; i++) begin
            drive(1, vecs[i].instr, vecs[i].rs1, vecs[i].rs2, 0, 0);
            cycle();
            check_outs(vecs[i].name, vecs[i].valid, vecs[i].ctrl, vecs[i].d1, vecs[i].d2, vecs[i].ill);
            check({vecs[i].name, " cnt"}, 32'(illegal_cnt_o), 32'(m_cnt));
        end

        // Stall holds everything (an illegal word during stall is not counted); flush beats stall.
        drive(1, 32'h40208033, 32'd10, 32'd3, 0, 0);
        cycle();
        check_outs("pre_stall", 1, 3'b001, 32'd10, 32'd3, 0);
        drive(1, 32'h0020F033, 32'd77, 32'd88, 1, 0);
        cycle();
        check_outs("stall1", 1, 3'b001, 32'd10, 32'd3, 0);
        drive(1, 32'h0020A033, 32'd55, 32'd66, 1, 0);
        cycle();
        check_outs("stall2", 1, 3'b001, 32'd10, 32'd3, 0);
        check("stall2 cnt", 32'(illegal_cnt_o), 32'd3);
        drive(1, 32'h0020F033, 32'd1, 32'd1, 1, 1);
        cycle();
        check_outs("stall_flush", 0, 3'b000, 32'd0, 32'd0, 0);
        check("stall_flush cnt", 32'(illegal_cnt_o), 32'd3);

        // Asynchronous reset in the middle of a stall, well away from any edge.
        drive(1, 32'h40208033, 32'd10, 32'd3, 0, 0);
        cycle();
        drive(1, 32'h40208033, 32'd10, 32'd3, 1, 0);
        #2;
        rst_i = 1'b1;
        model_reset();
        #1;
        check_outs("async_rst", 0, 3'b000, 32'd0, 32'd0, 0);
        check("async_rst cnt", 32'(illegal_cnt_o), 32'd0);
        check("async_rst cnt_s", 32'(s_illegal_cnt_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        drive(0, 32'h40208033, 32'd10, 32'd3, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("post_rst valid", 32'(valid_o), 32'd0);
        end

        // Illegal pulse, hold under stall, and counter saturation on the 2-bit instance.
        drive(1, 32'h0020A033, 32'd1, 32'd2, 0, 0);
        cycle();
        check_outs("ill1", 0, 3'b000, 32'd0, 32'd0, 1);
        check("ill1 cnt", 32'(illegal_cnt_o), 32'd1);
        drive(0, 32'h0020A033, 32'd1, 32'd2, 0, 0);
        cycle();
        check("ill_pulse_end", 32'(illegal_o), 32'd0);
        drive(1, 32'h0020A033, 32'd1, 32'd2, 0, 0);
        cycle();
        drive(1, 32'h0020A033, 32'd1, 32'd2, 1, 0);
        cycle();
        check("ill_held", 32'(illegal_o), 32'd1);
        check("ill_held cnt", 32'(illegal_cnt_o), 32'd2);
        drive(1, 32'h12345037, 32'd1, 32'd2, 0, 0);
        for (int i = 0; i < 3; i++) cycle();
        check("sat cnt", 32'(illegal_cnt_o), 32'd5);
        check("sat cnt_s", 32'(s_illegal_cnt_o), 32'd3);
        check_model("sat");

        for (int i = 0; i < 400; i++) begin
            logic [31:0] ins;
            ins = $urandom;
            case ($urandom_range(0, 6))
                0: ins[6:0] = 7'h33;
                1: ins[6:0] = 7'h13;
                2: ins[6:0] = 7'h03;
                3: ins[6:0] = 7'h23;
                4: ins[6:0] = 7'h63;
                5: ins[6:0] = 7'h13;
                default: ;
            endcase
            case ($urandom_range(0, 2))
                0: ins[31:25] = 7'h00;
                1: ins[31:25] = 7'h20;
                default: ;
            endcase
            drive(($urandom_range(0, 7) != 0), ins, $urandom, $urandom,
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0));
            cycle();
            check_model("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
